pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 redirect  input  1  SHALL request a PC load from redirect_pc.
REQ-005 redirect_pc  input  32  SHALL be the selected next-PC, the output of the PC-source 4:1 mux.
REQ-006 pc_plus4  output  32  SHALL equal pc+4, for mux input 0.
REQ-007 imem_req_valid / imem_req_ready  output / input  1 / 1  SHALL form the instruction-memory request handshake.
REQ-008 imem_addr  output  32  SHALL equal pc.
REQ-009 imem_rsp_valid / imem_rdata  input / input  1 / 32  SHALL carry the instruction-memory response.
REQ-010 if_valid, if_ready  output, input  1, 1  SHALL form the decode-side handshake.
REQ-011 if_pc / if_instr  output / output  32 / 32  SHALL carry the fetched instruction's address and word.
REQ-012 misalign_err  output  1  SHALL flag a misaligned redirect.

Function
REQ-013 FSM states SHALL be REQ, WAIT, DROP, HALT; at most one memory request outstanding.
REQ-014 REQ: imem_req_valid SHALL be (!if_valid || if_ready); on req handshake -> WAIT.
REQ-015 WAIT: on imem_rsp_valid, if_pc<=pc, if_instr<=imem_rdata, if_valid<=1, pc<=pc+4 (mod 2^32 wrap), -> REQ.
REQ-016 if_valid SHALL clear on an if_valid&&if_ready cycle unless refilled that same edge.
REQ-017 Response-to-if_valid latency SHALL be one cycle; back-to-back single-cycle memory SHALL yield one instruction per two cycles.
REQ-018 redirect in REQ SHALL load pc<=redirect_pc, clear if_valid, stay REQ; a same-cycle request handshake SHALL be suppressed.
REQ-019 redirect in WAIT SHALL load pc, clear if_valid, -> DROP; a same-cycle response SHALL be discarded and go to REQ instead.
REQ-020 DROP SHALL discard the next response without touching if_* or pc, then -> REQ; redirect in DROP reloads pc, stays DROP.
REQ-021 if_valid SHALL remain stable with if_pc/if_instr unchanged while if_ready=0.
REQ-022 imem_rsp_valid in REQ or HALT SHALL be ignored.

Reset
REQ-023 On rst: pc=RESET_VEC, state=REQ, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, imem_req_valid=0 during rst.
REQ-024 rst asserted mid-WAIT SHALL abandon the outstanding request; a response arriving after reset release in REQ is ignored per REQ-022.

Configuration
REQ-025 With PC_FETCH_MISALIGN_TRAP_EN defined, redirect with redirect_pc[1:0]!=0 SHALL set sticky misalign_err, clear if_valid, enter HALT (no requests) until rst.
REQ-026 Without PC_FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 2'b00 on load, misalign_err tied 0, HALT unreachable.

Structure
REQ-027 Shared package SHALL hold the FSM state enum (2-bit) and the RESET_VEC default constant.
REQ-028 No sub-module required; optional sub-module pc_reg (pc register with load/increment) permitted.

Verification
REQ-029 Reset, zero-wait memory, if_ready=1 -> if_pc sequence 0x0,0x4,0x8 with if_valid every other cycle.
REQ-030 if_ready=0 for 5 cycles after first fetch -> if_pc=0x0 held, imem_req_valid=0, no second request until if_ready=1.
REQ-031 redirect to 0x100 while in WAIT, response 0xDEADBEEF arrives 2 cycles later -> discarded; next if_pc=0x100.
REQ-032 redirect and imem_rsp_valid same cycle in WAIT -> response dropped, next request addr=redirect_pc.
REQ-033 pc=0xFFFF_FFFC fetched -> pc_plus4 and next imem_addr wrap to 0x0000_0000.
REQ-034 With macro, redirect_pc=0x102 -> misalign_err=1, imem_req_valid=0 until rst; without macro -> fetch addr 0x100.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// reset-vector default and small address helpers.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program counter register: reset to a vector, load on redirect, or step by one
// instruction word with natural 32-bit wrap.
module pc_fetch_pc_reg
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_VEC;
        end else if (load) begin
            pc_reg <= load_pc;
        end else if (inc) begin
            pc_reg <= pc_plus4;
        end
    end

    assign pc       = pc_reg;
    assign pc_plus4 = pc_reg + INSTR_BYTES;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: one outstanding memory request, redirect with response
// discard, and a registered decode-side output. Optional PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign_err
);

    fetch_state_t state_reg, state_next;

    logic [31:0] pc;
    logic [31:0] load_pc;
    logic        pc_load;
    logic        pc_inc;
    logic        fill;
    logic        kill_if;
    logic        req_valid;
    logic        trap;

    logic        if_valid_reg;
    logic [31:0] if_pc_reg;
    logic [31:0] if_instr_reg;

    assign load_pc = word_align(redirect_pc);

    pc_fetch_pc_reg #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_pc  (load_pc),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic err_reg;

    assign trap = redirect && is_misaligned(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (trap && (state_reg != ST_HALT)) begin
            err_reg <= 1'b1;
        end
    end

    assign misalign_err = err_reg;
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    // A redirect always wins over the normal flow; the in-flight response (if any)
    // becomes stale and must be swallowed before the next request goes out.
    always_comb begin
        state_next = state_reg;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        fill       = 1'b0;
        kill_if    = 1'b0;
        req_valid  = 1'b0;
        case (state_reg)
            ST_REQ: begin
                if (trap) begin
                    kill_if    = 1'b1;
                    state_next = ST_HALT;
                end else if (redirect) begin
                    pc_load = 1'b1;
                    kill_if = 1'b1;
                end else begin
                    req_valid = !if_valid_reg || if_ready;
                    if (req_valid && imem_req_ready) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (trap) begin
                    kill_if    = 1'b1;
                    state_next = ST_HALT;
                end else if (redirect) begin
                    pc_load    = 1'b1;
                    kill_if    = 1'b1;
                    state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    fill       = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (trap) begin
                    kill_if    = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    if (redirect) begin
                        pc_load = 1'b1;
                        kill_if = 1'b1;
                    end
                    // The discarded response also retires the only outstanding request.
                    if (imem_rsp_valid) begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_reg <= 1'b0;
            if_pc_reg    <= 32'h0;
            if_instr_reg <= 32'h0;
        end else if (fill) begin
            if_valid_reg <= 1'b1;
            if_pc_reg    <= pc;
            if_instr_reg <= imem_rdata;
        end else if (kill_if || (if_valid_reg && if_ready)) begin
            if_valid_reg <= 1'b0;
        end
    end

    assign imem_req_valid = req_valid && !rst;
    assign imem_addr      = pc;
    assign if_valid       = if_valid_reg;
    assign if_pc          = if_pc_reg;
    assign if_instr       = if_instr_reg;

endmodule
